// File: rtl/spi_frame_dispatcher.sv
// SPI frame dispatcher: stages per-phase duty words from SPI frames and commits them at the carrier peak, with a run watchdog.
// Optional build macro SPI_PARITY_CHECK_EN rejects frames with odd parity or nonzero reserved bits.
module spi_frame_dispatcher #(
   parameter logic [11:0] DUTY_MAX   = 12'd4000,
   parameter logic [11:0] DUTY_MID   = 12'd2000,
   parameter logic [23:0] WDT_CYCLES = 24'd2000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_valid,
   input  logic [26:0] frame_data,
   input  logic        carrier_sync,
   output logic [11:0] duty_a,
   output logic [11:0] duty_b,
   output logic [11:0] duty_c,
   output logic        duty_update,
   output logic        enable,
   output logic        fault,
   output logic [7:0]  frame_err_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      ARMED   = 2'd2,
      FAULT   = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [11:0] sh_a;
   logic [11:0] sh_b;
   logic [11:0] sh_c;
   logic [2:0]  mask;
   logic [23:0] wdt;

   logic [1:0]  addr;
   logic [11:0] value;
   logic [11:0] value_clamped;
   logic [2:0]  phase_bit;
   logic        frame_ok;
   logic        accepted;
   logic        is_phase;
   logic        is_ctrl;
   logic        run_req;
   logic        fault_clr;
   logic        running;
   logic        wdt_expired;

   logic        load_phase;
   logic        commit;
   logic        go_safe;
   logic        wdt_clear;

   assign addr  = frame_data[26:25];
   assign value = frame_data[24:13];

`ifdef SPI_PARITY_CHECK_EN
   assign frame_ok = ~(^frame_data) && (frame_data[12:1] == 12'd0);
`else
   logic unused_bits;
   assign unused_bits = ^frame_data[12:0];
   assign frame_ok    = 1'b1;
`endif

   assign accepted      = frame_valid && frame_ok;
   assign is_ctrl       = accepted && (addr == 2'b11);
   assign is_phase      = accepted && (addr != 2'b11);
   assign run_req       = value[0];
   assign fault_clr     = value[1];
   assign value_clamped = (value > DUTY_MAX) ? DUTY_MAX : value;
   assign running       = (state == COLLECT) || (state == ARMED);
   // An accepted frame in the expiry cycle keeps the watchdog alive.
   assign wdt_expired   = (wdt == (WDT_CYCLES - 24'd1)) && !accepted;
   assign fault         = (state == FAULT);

   always_comb begin
      phase_bit = 3'b000;
      case (addr)
         2'b00:   phase_bit = 3'b001;
         2'b01:   phase_bit = 3'b010;
         2'b10:   phase_bit = 3'b100;
         default: phase_bit = 3'b000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Stop request beats watchdog expiry, which beats a commit at the carrier peak.
   always_comb begin
      state_next = state;
      load_phase = 1'b0;
      commit     = 1'b0;
      go_safe    = 1'b0;
      wdt_clear  = 1'b0;
      case (state)
         IDLE: begin
            load_phase = is_phase;
            if (is_ctrl && run_req) begin
               state_next = COLLECT;
               wdt_clear  = 1'b1;
            end
         end
         COLLECT, ARMED: begin
            if (is_ctrl && !run_req) begin
               state_next = IDLE;
               go_safe    = 1'b1;
               wdt_clear  = 1'b1;
            end else if (wdt_expired) begin
               state_next = FAULT;
               go_safe    = 1'b1;
               wdt_clear  = 1'b1;
            end else begin
               load_phase = is_phase;
               wdt_clear  = accepted;
               if ((state == ARMED) && carrier_sync) begin
                  commit     = 1'b1;
                  state_next = COLLECT;
                  wdt_clear  = 1'b1;
               end else if ((state == COLLECT) && (mask == 3'b111)) begin
                  state_next = ARMED;
               end
            end
         end
         FAULT: begin
            if (is_ctrl && fault_clr) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Commit reads the shadows before this cycle's frame lands in them.
   always_ff @(posedge clk) begin
      if (reset) begin
         sh_a        <= DUTY_MID;
         sh_b        <= DUTY_MID;
         sh_c        <= DUTY_MID;
         mask        <= 3'b000;
         duty_a      <= DUTY_MID;
         duty_b      <= DUTY_MID;
         duty_c      <= DUTY_MID;
         duty_update <= 1'b0;
         enable      <= 1'b0;
         wdt         <= 24'd0;
      end else begin
         duty_update <= commit;

         if (go_safe) begin
            duty_a <= DUTY_MID;
            duty_b <= DUTY_MID;
            duty_c <= DUTY_MID;
            enable <= 1'b0;
         end else if (commit) begin
            duty_a <= sh_a;
            duty_b <= sh_b;
            duty_c <= sh_c;
            enable <= 1'b1;
         end

         if (load_phase) begin
            case (addr)
               2'b00:   sh_a <= value_clamped;
               2'b01:   sh_b <= value_clamped;
               2'b10:   sh_c <= value_clamped;
               default: ;
            endcase
         end

         if (go_safe) begin
            mask <= 3'b000;
         end else if (commit) begin
            mask <= load_phase ? phase_bit : 3'b000;
         end else if (load_phase) begin
            mask <= mask | phase_bit;
         end

         if (wdt_clear || !running) begin
            wdt <= 24'd0;
         end else begin
            wdt <= wdt + 24'd1;
         end
      end
   end

`ifdef SPI_PARITY_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_err_cnt <= 8'd0;
      end else if (frame_valid && !frame_ok && (frame_err_cnt != 8'hFF)) begin
         frame_err_cnt <= frame_err_cnt + 8'd1;
      end
   end
`else
   always_ff @(posedge clk) begin
      frame_err_cnt <= 8'd0;
   end
`endif

endmodule

// File: tb/tb_spi_frame_dispatcher.sv
// Randomized lockstep bench for spi_frame_dispatcher against a behavioural model of the frame/commit/watchdog rules.
// Honours SPI_PARITY_CHECK_EN in the same way as the design build.
module tb_spi_frame_dispatcher;

   localparam int MID  = 2000;
   localparam int MAXD = 4000;
   localparam int WDT  = 100;

   localparam int M_IDLE    = 0;
   localparam int M_COLLECT = 1;
   localparam int M_ARMED   = 2;
   localparam int M_FAULT   = 3;

   logic        clk;
   logic        reset;
   logic        frame_valid;
   logic [26:0] frame_data;
   logic        carrier_sync;
   logic [11:0] duty_a;
   logic [11:0] duty_b;
   logic [11:0] duty_c;
   logic        duty_update;
   logic        enable;
   logic        fault;
   logic [7:0]  frame_err_cnt;

   int total;
   int bad;

   int       mMode;
   int       mSh[3];
   bit [2:0] mStaged;
   int       mDuty[3];
   bit       mUpd;
   bit       mEn;
   int       mWdog;
   int       mErr;

   spi_frame_dispatcher #(
      .DUTY_MAX  (12'd4000),
      .DUTY_MID  (12'd2000),
      .WDT_CYCLES(24'd100)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .frame_valid  (frame_valid),
      .frame_data   (frame_data),
      .carrier_sync (carrier_sync),
      .duty_a       (duty_a),
      .duty_b       (duty_b),
      .duty_c       (duty_c),
      .duty_update  (duty_update),
      .enable       (enable),
      .fault        (fault),
      .frame_err_cnt(frame_err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [26:0] makeFrame(input logic [1:0] a, input logic [11:0] v);
      logic [26:0] f;
      f    = {a, v, 12'd0, 1'b0};
      f[0] = ^f[26:1];
      return f;
   endfunction

   task automatic modelGoSafe();
      for (int i = 0; i < 3; i++) mDuty[i] = MID;
      mEn     = 1'b0;
      mStaged = 3'b000;
      mWdog   = 0;
   endtask

   task automatic modelLoad(input int a, input int v);
      mSh[a]     = (v > MAXD) ? MAXD : v;
      mStaged[a] = 1'b1;
   endtask

   task automatic modelStep(input logic r, input logic fv, input logic [26:0] fd, input logic cs);
      bit ok;
      bit acc;
      bit isCtrl;
      bit committed;
      int a;
      int v;
      if (r) begin
         mMode = M_IDLE;
         for (int i = 0; i < 3; i++) mSh[i] = MID;
         modelGoSafe();
         mUpd = 1'b0;
         mErr = 0;
         return;
      end
      ok = 1'b1;
`ifdef SPI_PARITY_CHECK_EN
      ok = (^fd == 1'b0) && (fd[12:1] == 12'd0);
`endif
      acc = fv && ok;
      if (fv && !ok && mErr < 255) mErr++;
      a         = int'(fd[26:25]);
      v         = int'(fd[24:13]);
      isCtrl    = (a == 3);
      mUpd      = 1'b0;
      committed = 1'b0;
      case (mMode)
         M_IDLE: begin
            if (acc && !isCtrl) modelLoad(a, v);
            if (acc && isCtrl && (v & 1) != 0) begin
               mMode = M_COLLECT;
               mWdog = 0;
            end
         end
         M_COLLECT, M_ARMED: begin
            if (acc && isCtrl && (v & 1) == 0) begin
               mMode = M_IDLE;
               modelGoSafe();
            end else if (!acc && mWdog == WDT - 1) begin
               mMode = M_FAULT;
               modelGoSafe();
            end else begin
               if (mMode == M_ARMED && cs) begin
                  for (int i = 0; i < 3; i++) mDuty[i] = mSh[i];
                  mUpd      = 1'b1;
                  mEn       = 1'b1;
                  mStaged   = 3'b000;
                  mMode     = M_COLLECT;
                  committed = 1'b1;
               end else if (mMode == M_COLLECT && mStaged == 3'b111) begin
                  mMode = M_ARMED;
               end
               if (acc && !isCtrl) modelLoad(a, v);
               mWdog = (acc || committed) ? 0 : mWdog + 1;
            end
         end
         default: begin
            if (acc && isCtrl && (v & 2) != 0) mMode = M_IDLE;
         end
      endcase
   endtask

   task automatic compareAll();
      checkOutput("duty_a", 32'(duty_a), 32'(mDuty[0]));
      checkOutput("duty_b", 32'(duty_b), 32'(mDuty[1]));
      checkOutput("duty_c", 32'(duty_c), 32'(mDuty[2]));
      checkOutput("duty_update", 32'(duty_update), 32'(mUpd));
      checkOutput("enable", 32'(enable), 32'(mEn));
      checkOutput("fault", 32'(fault), 32'(mMode == M_FAULT));
      checkOutput("frame_err_cnt", 32'(frame_err_cnt), 32'(mErr));
   endtask

   task automatic applyStimulus(input logic r, input logic fv, input logic [26:0] fd, input logic cs);
      reset        = r;
      frame_valid  = fv;
      frame_data   = fd;
      carrier_sync = cs;
      @(posedge clk);
      modelStep(r, fv, fd, cs);
      #1;
      reset        = 1'b0;
      frame_valid  = 1'b0;
      carrier_sync = 1'b0;
      compareAll();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 27'd0, 1'b0);
   endtask

   task automatic sendFrame(input logic [1:0] a, input logic [11:0] v);
      applyStimulus(1'b0, 1'b1, makeFrame(a, v), 1'b0);
   endtask

   task automatic randomCycle(input int frameChance, input int syncChance);
      logic        fv;
      logic        cs;
      logic        r;
      logic [1:0]  a;
      logic [11:0] v;
      logic [26:0] fd;
      int          k;
      fv = ($urandom_range(99) < frameChance);
      cs = ($urandom_range(99) < syncChance);
      r  = ($urandom_range(799) == 0);
      a  = 2'($urandom_range(3));
      if (a == 2'b11) begin
         v    = 12'($urandom);
         v[0] = ($urandom_range(9) != 0);
         v[1] = ($urandom_range(2) == 0);
      end else if ($urandom_range(4) == 0) begin
         v = 12'($urandom_range(4095, 3900));
      end else begin
         v = 12'($urandom_range(4095));
      end
      fd = makeFrame(a, v);
      k  = int'($urandom_range(9));
      if (k == 0) fd = fd ^ 27'd1;
      else if (k == 1) fd = fd ^ 27'b110;
      applyStimulus(r, fv, fd, cs);
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      reset        = 1'b1;
      frame_valid  = 1'b0;
      frame_data   = 27'd0;
      carrier_sync = 1'b0;

      applyStimulus(1'b1, 1'b0, 27'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, makeFrame(2'b11, 12'd1), 1'b1);
      checkOutput("rst_duty_a", 32'(duty_a), 32'd2000);
      checkOutput("rst_enable", 32'(enable), 32'd0);
      checkOutput("rst_fault", 32'(fault), 32'd0);

      sendFrame(2'b11, 12'd1);
      sendFrame(2'b00, 12'd1000);
      sendFrame(2'b01, 12'd2000);
      sendFrame(2'b10, 12'd3000);
      idleCycles(1);
      applyStimulus(1'b0, 1'b0, 27'd0, 1'b1);
      checkOutput("basic_a", 32'(duty_a), 32'd1000);
      checkOutput("basic_b", 32'(duty_b), 32'd2000);
      checkOutput("basic_c", 32'(duty_c), 32'd3000);
      checkOutput("basic_upd", 32'(duty_update), 32'd1);
      checkOutput("basic_en", 32'(enable), 32'd1);
      idleCycles(1);
      checkOutput("upd_pulse_end", 32'(duty_update), 32'd0);

      sendFrame(2'b00, 12'd4095);
      sendFrame(2'b01, 12'd2500);
      sendFrame(2'b10, 12'd3500);
      idleCycles(1);
      applyStimulus(1'b0, 1'b0, 27'd0, 1'b1);
      checkOutput("clamp_a", 32'(duty_a), 32'd4000);

      sendFrame(2'b00, 12'd100);
      sendFrame(2'b01, 12'd200);
      sendFrame(2'b10, 12'd300);
      idleCycles(1);
      applyStimulus(1'b0, 1'b1, makeFrame(2'b00, 12'd500), 1'b1);
      checkOutput("same_cycle_old_a", 32'(duty_a), 32'd100);
      sendFrame(2'b01, 12'd600);
      sendFrame(2'b10, 12'd700);
      idleCycles(1);
      applyStimulus(1'b0, 1'b0, 27'd0, 1'b1);
      checkOutput("kept_mask_a", 32'(duty_a), 32'd500);
      checkOutput("kept_mask_c", 32'(duty_c), 32'd700);

      idleCycles(99);
      checkOutput("wdt_not_yet", 32'(fault), 32'd0);
      idleCycles(1);
      checkOutput("wdt_fault", 32'(fault), 32'd1);
      checkOutput("wdt_enable", 32'(enable), 32'd0);
      checkOutput("wdt_duty_b", 32'(duty_b), 32'd2000);
      applyStimulus(1'b0, 1'b1, makeFrame(2'b00, 12'd123), 1'b1);
      sendFrame(2'b11, 12'd1);
      checkOutput("fault_sticky", 32'(fault), 32'd1);
      sendFrame(2'b11, 12'd2);
      checkOutput("fault_clear", 32'(fault), 32'd0);

      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b0, 1'b1, makeFrame(2'b00, 12'd77) ^ 27'd1, 1'b0);
      end
`ifdef SPI_PARITY_CHECK_EN
      checkOutput("err_saturate", 32'(frame_err_cnt), 32'd255);
`else
      checkOutput("err_held_zero", 32'(frame_err_cnt), 32'd0);
`endif
      sendFrame(2'b11, 12'd1);
      sendFrame(2'b01, 12'd1);
      sendFrame(2'b10, 12'd2);
      idleCycles(1);
      applyStimulus(1'b0, 1'b0, 27'd0, 1'b1);
`ifdef SPI_PARITY_CHECK_EN
      checkOutput("bad_frames_ignored", 32'(duty_a), 32'd2000);
`else
      checkOutput("bad_frames_loaded", 32'(duty_a), 32'd77);
`endif

      for (int i = 0; i < 2500; i++) randomCycle(40, 15);
      for (int i = 0; i < 1500; i++) randomCycle(3, 10);

      applyStimulus(1'b1, 1'b1, makeFrame(2'b11, 12'd1), 1'b1);
      checkOutput("final_rst_en", 32'(enable), 32'd0);
      checkOutput("final_rst_err", 32'(frame_err_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
